// File: rtl/axis_matrix_src.sv
// AXI4-Stream source that emits a rows x cols matrix, row-major, with elements (r*row_k + c*col_k + offset) mod 2^DW.
// Optional build macro AXIS_SRC_THROTTLE_EN adds a throttle_en input that gaps beats using an LFSR.
module axis_matrix_src #(
  parameter int DW           = 8,
  parameter int DIM_W        = 6,
  parameter bit LAST_PER_ROW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [DIM_W-1:0] rows,
  input  logic [DIM_W-1:0] cols,
  input  logic [DW-1:0]    row_k,
  input  logic [DW-1:0]    col_k,
  input  logic [DW-1:0]    offset,
`ifdef AXIS_SRC_THROTTLE_EN
  input  logic             throttle_en,
`endif
  output logic [DW-1:0]    m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state_q, state_d;

  logic [DIM_W-1:0] rows_q, cols_q, r_q, c_q;
  logic [DW-1:0]    row_k_q, col_k_q, offset_q;

  logic             accept, empty, xfer, row_end, mat_end, advance, hold, done_d;
  logic [DIM_W-1:0] nr, nc, src_rows, src_cols;
  logic [DW-1:0]    src_rk, src_ck, src_off, elem;
  logic             elem_last;
  logic [DIM_W+DW-1:0] prod_r, prod_c;

`ifdef AXIS_SRC_THROTTLE_EN
  // Fibonacci LFSR, taps 16,14,13,11; free-runs every clock
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign hold = throttle_en & ~lfsr[0];
`else
  assign hold = 1'b0;
`endif

  assign accept  = (state_q == IDLE) && start && (rows != '0) && (cols != '0);
  assign empty   = (state_q == IDLE) && start && ((rows == '0) || (cols == '0));
  assign xfer    = (state_q == RUN) && m_axis_tvalid && m_axis_tready;
  assign row_end = (c_q == cols_q - DIM_W'(1));
  assign mat_end = row_end && (r_q == rows_q - DIM_W'(1));
  // a new beat may be loaded when starting, after a transfer, or into an empty (throttled) slot
  assign advance = accept || ((state_q == RUN) && (xfer || !m_axis_tvalid));

  // Next element index and the coefficient set it is evaluated with;
  // on start the latches are not yet loaded, so the inputs are used directly.
  always_comb begin
    nr       = r_q;
    nc       = c_q;
    src_rows = rows_q;
    src_cols = cols_q;
    src_rk   = row_k_q;
    src_ck   = col_k_q;
    src_off  = offset_q;
    if (accept) begin
      nr       = '0;
      nc       = '0;
      src_rows = rows;
      src_cols = cols;
      src_rk   = row_k;
      src_ck   = col_k;
      src_off  = offset;
    end else if (xfer) begin
      nc = row_end ? '0 : c_q + DIM_W'(1);
      nr = row_end ? r_q + DIM_W'(1) : r_q;
    end
  end

  assign prod_r = {{DW{1'b0}}, nr} * {{DIM_W{1'b0}}, src_rk};
  assign prod_c = {{DW{1'b0}}, nc} * {{DIM_W{1'b0}}, src_ck};
  assign elem   = prod_r[DW-1:0] + prod_c[DW-1:0] + src_off;

  always_comb begin
    elem_last = (nc == src_cols - DIM_W'(1));
    if (!LAST_PER_ROW) elem_last = elem_last && (nr == src_rows - DIM_W'(1));
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = RUN;
        if (empty)  done_d  = 1'b1;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (xfer && mat_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rows_q        <= '0;
      cols_q        <= '0;
      row_k_q       <= '0;
      col_k_q       <= '0;
      offset_q      <= '0;
      r_q           <= '0;
      c_q           <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= done_d;
      if (accept) begin
        rows_q   <= rows;
        cols_q   <= cols;
        row_k_q  <= row_k;
        col_k_q  <= col_k;
        offset_q <= offset;
      end
      if ((state_q == RUN) && (abort || (xfer && mat_end))) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        r_q           <= '0;
        c_q           <= '0;
      end else if (advance) begin
        r_q <= nr;
        c_q <= nc;
        if (!hold) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= elem;
          m_axis_tlast  <= elem_last;
        end else begin
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
        end
      end
    end
  end

  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_axis_matrix_src.sv
// Directed bench for axis_matrix_src: whole-matrix runs, stalls, wrap, empty dims, per-row tlast, abort, reset.
module tb_axis_matrix_src;
  localparam int DW = 8, DIM_W = 6;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, tready = 1'b0;
  logic [DIM_W-1:0] rows = '0, cols = '0;
  logic [DW-1:0]    row_k = '0, col_k = '0, offset = '0;
  logic [DW-1:0]    tdata, tdata_r;
  logic             tvalid, tlast, busy, done, tvalid_r, tlast_r, busy_r, done_r;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  axis_matrix_src #(.DW(DW), .DIM_W(DIM_W), .LAST_PER_ROW(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rows(rows), .cols(cols), .row_k(row_k), .col_k(col_k), .offset(offset),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .busy(busy), .done(done));

  axis_matrix_src #(.DW(DW), .DIM_W(DIM_W), .LAST_PER_ROW(1'b1)) u_dut_row (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rows(rows), .cols(cols), .row_k(row_k), .col_k(col_k), .offset(offset),
    .m_axis_tdata(tdata_r), .m_axis_tvalid(tvalid_r), .m_axis_tready(tready),
    .m_axis_tlast(tlast_r), .busy(busy_r), .done(done_r));

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Launches one matrix and checks every presented beat against the affine model.
  task automatic run_matrix(input int nr, input int nc, input int rk, input int ck,
                            input int off, input bit toggle, input int last_val);
    int k, total, budget, dones, lastd;
    bit rdy;
    k = 0; total = nr * nc; budget = total * 3 + 20; dones = 0; lastd = -1; rdy = 1'b1;
    @(negedge clk);
    rows = DIM_W'(nr); cols = DIM_W'(nc); row_k = DW'(rk); col_k = DW'(ck); offset = DW'(off);
    start = 1'b1; tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_valid", 32'(tvalid), 1);
    while (k < total && budget > 0) begin
      if (done) dones++;
      if (tvalid) begin
        chk("tdata", 32'(tdata), (((k / nc) * rk) + ((k % nc) * ck) + off) & 255);
        chk("tlast", 32'(tlast), (k == total - 1) ? 1 : 0);
        chk("tlast_row", 32'(tlast_r), ((k % nc) == nc - 1) ? 1 : 0);
      end
      if (toggle) rdy = ~rdy;
      tready = rdy;
      if (tvalid && rdy) begin
        lastd = 32'(tdata);
        k++;
      end
      @(negedge clk);
      budget--;
    end
    chk("beat_count", k, total);
    chk("no_early_done", dones, 0);
    chk("done_pulse", 32'(done), 1);
    chk("valid_after_end", 32'(tvalid), 0);
    chk("busy_after_end", 32'(busy), 0);
    if (last_val >= 0) chk("last_value", lastd, last_val);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 0);
  endtask

  initial begin
    #1;
    chk("rst_tvalid", 32'(tvalid), 0);
    chk("rst_tdata", 32'(tdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_matrix(25, 19, 1, 1, 0, 1'b0, 24 + 18);
    run_matrix(19, 17, 2, 1, 1, 1'b1, 53);
    run_matrix(3, 3, 200, 100, 255, 1'b0, 87);
    run_matrix(4, 8, 3, 5, 7, 1'b0, (9 + 35 + 7) & 255);

    // zero dimension: done only, no beats
    @(negedge clk);
    rows = '0; cols = DIM_W'(5); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("empty_done", 32'(done), 1);
    chk("empty_valid", 32'(tvalid), 0);
    chk("empty_busy", 32'(busy), 0);
    @(negedge clk);
    chk("empty_done_clr", 32'(done), 0);
    chk("empty_valid2", 32'(tvalid), 0);

    // abort after 10 beats with sink stalled
    rows = DIM_W'(25); cols = DIM_W'(19); row_k = 8'd1; col_k = 8'd1; offset = 8'd0;
    start = 1'b1; tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_abort_data", 32'(tdata), 10);
    tready = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", 32'(tvalid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    @(negedge clk);
    chk("abort_done2", 32'(done), 0);
    run_matrix(3, 3, 1, 1, 0, 1'b0, 4);

    // asynchronous reset mid-matrix
    @(negedge clk);
    rows = DIM_W'(4); cols = DIM_W'(4); row_k = 8'd1; col_k = 8'd2; offset = 8'd3;
    start = 1'b1; tready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(tvalid), 0);
    chk("mid_rst_data", 32'(tdata), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_last", 32'(tlast), 0);
    chk("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_matrix(2, 3, 1, 2, 3, 1'b0, 1 + 4 + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
